countdown_timer: RTL and testbench

- Loadable two-digit BCD countdown timer, the down-counting counterpart of the team's seconds up-counter.
- Holds a preset from 00 to 99 and decrements once per second while running. Asserts done when it reaches 00.
- Uses an internal clock-enable prescaler on the single system clock, so no derived clock is needed.
- Digit outputs drive the board's seven-segment decoders directly.

---
 rtl/countdown_timer.sv | 137 +++++++++++++
 tb/tb_countdown_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable two-digit BCD countdown timer with a clock-enable prescaler.
// Counts down once per TICK_DIV cycles while running and holds DONE at 00.
module countdown_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] ten_digits,
    output logic [3:0] one_digits,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             load_err_q, load_err_d;

    logic             tick;
    logic             preset_ok;
    logic             at_zero;
    logic             start_v;
    logic             stop_v;
    logic [7:0]       dec;

    // Borrow from tens when ones is 0; 00 is a floor, never wraps to 99.
    function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
        if (o != 4'd0)
            return {t, o - 4'd1};
        else if (t != 4'd0)
            return {t - 4'd1, 4'd9};
        else
            return 8'h00;
    endfunction

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        load_err_d = 1'b0;

        tick      = (state_q == S_RUN) && (presc_q == TICK_MAX);
        preset_ok = (load_tens <= 4'd9) && (load_ones <= 4'd9);
        at_zero   = (tens_q == 4'd0) && (ones_q == 4'd0);
        dec       = bcd_dec(tens_q, ones_q);
        start_v   = start && !stop && !load;
        stop_v    = stop && !load;

        if (load && preset_ok) begin
            tens_d  = load_tens;
            ones_d  = load_ones;
            presc_d = '0;
            state_d = S_IDLE;
        end else begin
            // A rejected load flags the error and otherwise lets counting carry on.
            load_err_d = load;
            case (state_q)
                S_IDLE: begin
                    if (start_v) begin
                        presc_d = '0;
                        state_d = at_zero ? S_DONE : S_RUN;
                    end
                end
                S_PAUSED: begin
                    if (start_v)
                        state_d = at_zero ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        tens_d  = dec[7:4];
                        ones_d  = dec[3:0];
                        if (dec == 8'h00)
                            state_d = S_DONE;
                        else if (stop_v)
                            state_d = S_PAUSED;
                    end else begin
                        presc_d = presc_q + CNT_W'(1);
                        if (stop_v)
                            state_d = S_PAUSED;
                    end
                end
                default: ;
            endcase
        end

        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign ten_digits = tens_q;
    assign one_digits = ones_q;
    assign running    = running_q;
    assign done       = done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4.
module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       start;
    logic       stop;
    logic [3:0] ten_digits;
    logic [3:0] one_digits;
    logic       running;
    logic       done;
    logic       load_err;

    int total = 0;
    int bad   = 0;

    countdown_timer #(
        .TICK_DIV(4),
        .CNT_W   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .start     (start),
        .stop      (stop),
        .ten_digits(ten_digits),
        .one_digits(one_digits),
        .running   (running),
        .done      (done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load_tens = t;
        load_ones = o;
        load      = 1'b1;
        step(1);
        load      = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        load      = 1'b0;
        load_tens = 4'd0;
        load_ones = 4'd0;
        start     = 1'b0;
        stop      = 1'b0;

        // reset held low with random strobes
        for (int i = 0; i < 6; i++) begin
            load      = 1'($urandom_range(0, 1));
            start     = 1'($urandom_range(0, 1));
            stop      = 1'($urandom_range(0, 1));
            load_tens = 4'($urandom_range(0, 15));
            load_ones = 4'($urandom_range(0, 15));
            step(1);
        end
        chk("rst_digits", {ten_digits, one_digits}, 8'h00);
        chk("rst_flags", {5'd0, done, running, load_err}, 8'h00);
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b1;
        step(3);
        chk("post_rst_digits", {ten_digits, one_digits}, 8'h00);
        chk("post_rst_flags", {5'd0, done, running, load_err}, 8'h00);

        // full countdown from 25
        do_load(4'd2, 4'd5);
        chk("load25", {ten_digits, one_digits}, 8'h25);
        do_start();                       // edge N
        chk("run_N", {7'd0, running}, 8'h01);
        step(3);
        chk("cnt_N3", {ten_digits, one_digits}, 8'h25);
        step(1);
        chk("cnt_N4", {ten_digits, one_digits}, 8'h24);
        step(16);
        chk("cnt_N20", {ten_digits, one_digits}, 8'h20);
        step(4);
        chk("cnt_N24", {ten_digits, one_digits}, 8'h19);
        step(75);
        chk("cnt_N99", {ten_digits, one_digits}, 8'h01);
        chk("flags_N99", {6'd0, done, running}, 8'h01);
        step(1);
        chk("cnt_N100", {ten_digits, one_digits}, 8'h00);
        chk("flags_N100", {6'd0, done, running}, 8'h02);
        step(20);
        chk("hold_done", {ten_digits, one_digits}, 8'h00);
        chk("hold_flags", {6'd0, done, running}, 8'h02);
        do_start();
        step(5);
        chk("start_in_done", {6'd0, done, running}, 8'h02);

        // invalid load
        do_load(4'd1, 4'd7);
        chk("load17", {ten_digits, one_digits}, 8'h17);
        do_load(4'd3, 4'd10);
        chk("err_pulse", {7'd0, load_err}, 8'h01);
        chk("err_digits", {ten_digits, one_digits}, 8'h17);
        chk("err_state", {6'd0, done, running}, 8'h00);
        step(1);
        chk("err_clear", {7'd0, load_err}, 8'h00);
        chk("err_digits2", {ten_digits, one_digits}, 8'h17);

        // pause / resume
        do_load(4'd1, 4'd2);
        do_start();                       // edge N
        step(4);
        chk("pr_N4", {ten_digits, one_digits}, 8'h11);
        step(1);
        stop = 1'b1;
        step(1);                          // edge N+6
        stop = 1'b0;
        chk("pr_stop", {ten_digits, one_digits, 7'd0, running}, 16'h1100);
        step(20);
        chk("pr_hold", {ten_digits, one_digits, 7'd0, running}, 16'h1100);
        do_start();                       // edge M
        chk("pr_M", {ten_digits, one_digits, 7'd0, running}, 16'h1101);
        step(1);
        chk("pr_M1", {ten_digits, one_digits}, 8'h11);
        step(1);
        chk("pr_M2", {ten_digits, one_digits}, 8'h10);
        step(4);
        chk("pr_M6", {ten_digits, one_digits}, 8'h09);

        // edge strobes
        do_load(4'd0, 4'd0);
        chk("load00", {ten_digits, one_digits, 6'd0, done, running}, 16'h0000);
        do_start();
        chk("start00", {6'd0, done, running}, 8'h02);
        do_load(4'd4, 4'd2);
        chk("reload42", {6'd0, done, running}, 8'h00);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_idle", {6'd0, done, running}, 8'h00);
        step(5);
        chk("ss_hold", {ten_digits, one_digits}, 8'h42);
        do_start();
        chk("run42", {7'd0, running}, 8'h01);
        start = 1'b1;
        do_load(4'd3, 4'd3);
        start = 1'b0;
        chk("ld_start", {ten_digits, one_digits, 7'd0, running}, 16'h3300);
        step(6);
        chk("ld_start_hold", {ten_digits, one_digits}, 8'h33);
        do_load(4'd0, 4'd1);
        do_start();                       // edge N
        step(3);
        stop = 1'b1;
        step(1);                          // edge N+4, tick at 01
        stop = 1'b0;
        chk("stop_tick01", {ten_digits, one_digits, 6'd0, done, running}, 16'h0002);

        // reload from DONE and async reset mid-run
        do_load(4'd0, 4'd3);
        chk("reload03", {ten_digits, one_digits, 6'd0, done, running}, 16'h0300);
        do_start();                       // edge N
        step(5);
        chk("run_02", {ten_digits, one_digits, 7'd0, running}, 16'h0201);
        #3;
        reset = 1'b0;
        #1;
        chk("async_digits", {ten_digits, one_digits}, 8'h00);
        chk("async_flags", {5'd0, done, running, load_err}, 8'h00);
        step(2);
        reset = 1'b1;
        step(6);
        chk("after_rst", {ten_digits, one_digits, 6'd0, done, running}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
